sdma_req_arbiter: RTL

- Shares one SDMA channel (channel 0 Req/Done/Active) among NUM_REQ fabric requesters, e.g. the I2S RX FIFO drain and a second AEC reference/output stream.
- Round-robin arbitration; the grant is held for one complete DMA transfer.
- Sequences the Req→Active→Done handshake and returns a per-client done pulse.
- Sits between the client FIFO logic and the SDMA_Req/SDMA_Done/SDMA_Active pins of the cell macro.

---
 rtl/sdma_req_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sdma_req_arbiter.sv
// Round-robin arbiter sharing one SDMA channel among NUM_REQ clients; owns the Req/Active/Done handshake.
// Optional watchdog enabled by defining SDMA_ARB_TIMEOUT_EN.
module sdma_req_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_W     = 1,
  parameter int TIMEOUT_W = 16
) (
  input  logic               WB_CLK,
  input  logic               WB_RSTn,
  input  logic [NUM_REQ-1:0] Req_i,
  input  logic [NUM_REQ-1:0] Enable_i,
  output logic [NUM_REQ-1:0] Grant_o,
  output logic [NUM_REQ-1:0] Done_o,
  output logic [IDX_W-1:0]   Cur_Client_o,
  output logic               Busy_o,
  output logic               SDMA_Req_o,
  input  logic               SDMA_Done_i,
  input  logic               SDMA_Active_i,
  output logic               Err_Timeout_o,
  input  logic               Err_Clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int                 CW        = IDX_W + 1;
  localparam logic [NUM_REQ-1:0] GRANT_LSB = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic               sdma_req_q, sdma_req_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [CW-1:0]      cand;
  logic               timeout_hit;

  assign eligible = Req_i & Enable_i;

  // Search starts just after the previous owner, so the previous owner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = cur_q;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, cur_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!win_found && eligible[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

`ifdef SDMA_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + TIMEOUT_W'(1);

  // A completed transfer wins over a watchdog expiry in the same cycle.
  assign timeout_hit = ((state_q == ST_REQ) || (state_q == ST_ACTIVE)) &&
                       !SDMA_Done_i && (&cnt_inc);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if ((state_q == ST_REQ) || (state_q == ST_ACTIVE)) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_err_clr;

  assign timeout_hit    = 1'b0;
  assign unused_err_clr = Err_Clr_i;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cur_d      = cur_q;
    sdma_req_d = sdma_req_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d    = GRANT_LSB << win_idx;
          cur_d      = win_idx;
          sdma_req_d = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (SDMA_Done_i) begin
          sdma_req_d = 1'b0;
          state_d    = ST_DONE;
        end else if (SDMA_Active_i) begin
          sdma_req_d = 1'b0;
          state_d    = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (SDMA_Done_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog abort: the failed client keeps Cur_Client_o, so others get the next turn.
    if (timeout_hit) begin
      grant_d    = '0;
      sdma_req_d = 1'b0;
      state_d    = ST_IDLE;
    end
  end

  always_comb begin
    err_d = err_q;
    if (Err_Clr_i) begin
      err_d = 1'b0;
    end else if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      cur_q      <= LAST_IDX;
      sdma_req_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cur_q      <= cur_d;
      sdma_req_q <= sdma_req_d;
      err_q      <= err_d;
    end
  end

  assign Grant_o       = grant_q;
  assign Done_o        = (state_q == ST_DONE) ? grant_q : '0;
  assign Cur_Client_o  = cur_q;
  assign Busy_o        = (state_q != ST_IDLE);
  assign SDMA_Req_o    = sdma_req_q;
  assign Err_Timeout_o = err_q;

  a_grant_onehot0: assert property (@(posedge WB_CLK) disable iff (!WB_RSTn)
    $onehot0(Grant_o));
  a_done_in_grant: assert property (@(posedge WB_CLK) disable iff (!WB_RSTn)
    ((Done_o & ~Grant_o) == '0));

endmodule
